// File: rtl/jesd204_rx_descrambler_mon.sv
// JESD204 receive-lane descrambler (1 + x^14 + x^15) with a sync tracker and a
// saturating counter of non-zero payload beats seen while synced.
module jesd204_rx_descrambler_mon #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 check_en,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 synced,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int NBYTES = WIDTH / 8;
  localparam logic [14:0] STATE_SEED = 15'h7f80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SYNC  = 2'd2
  } sync_state_t;

  // Handshake: a beat is transferred on every clk edge where in_valid = 1; the
  // block never stalls. out_valid is in_valid delayed by exactly one cycle, and
  // out_data/synced are meaningful only while out_valid = 1.

  sync_state_t      sync_cur;
  sync_state_t      sync_nxt;
  logic [14:0]      scr_state;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] tap15;
  logic [WIDTH-1:0] tap14;
  logic [WIDTH-1:0] desc_w;
  logic [WIDTH-1:0] desc_data;
  logic [WIDTH-1:0] next_data;
  logic             err_hit;

  // Lane byte 0 is first on the wire, so it lands in the top byte of w; the
  // bit stream then reads MSB-first across the whole internal word.
  always_comb begin
    w = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w[WIDTH-1-8*i -: 8] = in_data[8*i +: 8];
    end
  end

  // Older bits sit above w: tap15 is s[n-15], tap14 is s[n-14].
  assign tap15  = {scr_state, w[WIDTH-1:15]};
  assign tap14  = {scr_state[13:0], w[WIDTH-1:14]};
  assign desc_w = tap15 ^ tap14 ^ w;

  always_comb begin
    desc_data = '0;
    for (int i = 0; i < NBYTES; i++) begin
      desc_data[8*i +: 8] = desc_w[WIDTH-1-8*i -: 8];
    end
  end

  assign next_data = enable ? desc_data : in_data;

  always_comb begin
    sync_nxt = sync_cur;
    case (sync_cur)
      IDLE:    if (enable) sync_nxt = PRIME;
      PRIME:   if (in_valid) sync_nxt = SYNC;
      SYNC:    sync_nxt = SYNC;
      default: sync_nxt = IDLE;
    endcase
    if (!enable) sync_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_cur <= IDLE;
    end else begin
      sync_cur <= sync_nxt;
    end
  end

  // The descrambler history tracks the line even in passthrough, so a later
  // enable only needs one beat to flush seed-dependent bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scr_state <= STATE_SEED;
      out_valid <= 1'b0;
      out_data  <= '0;
      synced    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      synced    <= in_valid && enable && (sync_cur == SYNC);
      if (in_valid) begin
        scr_state <= w[14:0];
        out_data  <= next_data;
      end
    end
  end

  assign err_hit = synced && check_en && out_valid && (|out_data);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_hit && !(&err_cnt)) begin
      err_cnt <= err_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_jesd204_rx_descrambler_mon.sv
// Directed bench for jesd204_rx_descrambler_mon: reset, passthrough, impulse,
// error counter (16-bit and saturating 2-bit instances), enable toggle, round trip.
module tb_jesd204_rx_descrambler_mon;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        in_valid;
  logic [31:0] in_data;
  logic        check_en;
  logic        err_clr;
  logic        out_valid;
  logic [31:0] out_data;
  logic        synced;
  logic [15:0] err_cnt;
  logic        out_valid_s;
  logic [31:0] out_data_s;
  logic        synced_s;
  logic [1:0]  err_cnt_s;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [14:0] scr_state;

  jesd204_rx_descrambler_mon #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .check_en(check_en), .err_clr(err_clr),
    .out_valid(out_valid), .out_data(out_data), .synced(synced), .err_cnt(err_cnt)
  );

  jesd204_rx_descrambler_mon #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .resetn(resetn), .enable(enable), .in_valid(in_valid),
    .in_data(in_data), .check_en(check_en), .err_clr(err_clr),
    .out_valid(out_valid_s), .out_data(out_data_s), .synced(synced_s), .err_cnt(err_cnt_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one cycle of input, then sample just after the edge
  task automatic drive_beat(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] byte_rev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // reference scrambler: s[n] = d[n] ^ s[n-14] ^ s[n-15], serial MSB-first
  task automatic scramble(input logic [31:0] d, output logic [31:0] s);
    logic [31:0] bits;
    logic [46:0] f;
    bits = byte_rev(d);
    f = {scr_state, 32'h0};
    for (int j = 31; j >= 0; j--) begin
      f[j] = bits[j] ^ f[j+14] ^ f[j+15];
    end
    scr_state = f[14:0];
    s = byte_rev(f[31:0]);
  endtask

  initial begin
    logic [31:0] src;
    logic [31:0] scr;
    logic [31:0] exp_d;
    logic        first;
    int          popped;

    resetn = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0;
    check_en = 1'b0; err_clr = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_synced", synced, 0);
    check("rst_err_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;

    // passthrough, then hold on a gap
    drive_beat(1'b1, 32'h12345678);
    check("pass_data", out_data, 32'h12345678);
    check("pass_valid", out_valid, 1);
    check("pass_synced", synced, 0);
    drive_beat(1'b0, 32'hdeadbeef);
    check("gap_valid", out_valid, 0);
    check("gap_hold", out_data, 32'h12345678);

    // impulse: IDLE -> PRIME on an idle cycle, prime beat, then a single bit
    enable = 1'b1;
    drive_beat(1'b0, 32'h0);
    drive_beat(1'b1, 32'h0);
    check("prime_synced", synced, 0);
    drive_beat(1'b1, 32'h00000080);
    check("imp_data", out_data, 32'h00000380);
    check("imp_synced", synced, 1);
    drive_beat(1'b1, 32'h0);
    check("imp_tail", out_data, 32'h0);
    check("imp_tail_synced", synced, 1);

    // error counter: three failing beats, counted one edge later each
    check_en = 1'b1;
    repeat (3) drive_beat(1'b1, 32'h00000080);
    check("err_two_so_far", err_cnt, 2);
    drive_beat(1'b0, 32'h0);
    check("err_three", err_cnt, 3);
    check("err_three_sat", err_cnt_s, 3);
    drive_beat(1'b1, 32'h00000080);
    err_clr = 1'b1;
    drive_beat(1'b0, 32'h0);
    err_clr = 1'b0;
    check("err_clr_wins", err_cnt, 0);
    check("err_clr_wins_sat", err_cnt_s, 0);
    repeat (5) drive_beat(1'b1, 32'h00000080);
    drive_beat(1'b0, 32'h0);
    check("err_five", err_cnt, 5);
    check("err_saturated", err_cnt_s, 3);
    check_en = 1'b0;

    // enable dropped for one beat mid-stream
    drive_beat(1'b1, 32'h0);
    check("tog_a_synced", synced, 1);
    enable = 1'b0;
    drive_beat(1'b1, 32'h0000aa55);
    check("tog_b_data", out_data, 32'h0000aa55);
    check("tog_b_synced", synced, 0);
    enable = 1'b1;
    drive_beat(1'b1, 32'h0);
    check("tog_c_synced", synced, 0);
    drive_beat(1'b1, 32'h0);
    check("tog_d_synced", synced, 0);
    drive_beat(1'b1, 32'h0);
    check("tog_e_synced", synced, 1);
    check("tog_e_data", out_data, 32'h0);

    // asynchronous reset in the middle of a beat
    check_en = 1'b1;
    drive_beat(1'b1, 32'h00000080);
    drive_beat(1'b1, 32'h00000080);
    in_valid = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_synced", synced, 0);
    check("mid_rst_err", err_cnt, 0);
    check("mid_rst_data", out_data, 0);
    #2 resetn = 1'b1;
    check_en = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_no_beat", out_valid, 0);

    // round trip through the reference scrambler, with random gaps
    scr_state = 15'h7f80;
    first = 1'b1;
    popped = 0;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive_beat(1'b0, $urandom);
        check("rt_gap_valid", out_valid, 0);
      end
      src = $urandom;
      scramble(src, scr);
      exp_q.push_back(src);
      drive_beat(1'b1, scr);
      if (out_valid) begin
        exp_d = exp_q.pop_front();
        popped++;
        if (first) begin
          check("rt_first_unsynced", synced, 0);
          first = 1'b0;
        end else if (synced) begin
          check("rt_data", out_data, exp_d);
        end
      end else begin
        check("rt_missing_valid", 1, 0);
      end
    end
    check("rt_all_popped", popped, 1000);
    check("rt_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
